// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared types and constants for the board front-end key control.
//   step_state_t : manual step FSM encoding (IDLE, FIRE, HELD)
//   SYNC_STAGES  : depth of the key / switch synchronisers
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HELD = 2'd2
  } step_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/step_ctrl_key_debounce.sv
// key_debounce: synchronises one raw active-low push-button into clk50,
// inverts it to active-high and debounces it.
//   clk50  in  board clock
//   reset  in  asynchronous, active-high reset
//   key_n  in  raw key, active-low, asynchronous to clk50
//   level  out accepted (debounced) key level, active-high, registered
// A level change is accepted once the synchronised input has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk50,
  input  logic reset,
  input  logic key_n,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;

  // Synchroniser resets to '1 so a key held through reset looks released
  // and must be re-qualified afterwards.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end
  end

  assign synced = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: board front-end control. Debounces the step and peek keys and
// produces a single-cycle processor step enable plus a clean peek level.
//   clk50       in  50 MHz board clock (only clock)
//   reset       in  asynchronous, active-high reset
//   key_step_n  in  raw step key, active-low
//   key_peek_n  in  raw peek key, active-low
//   run_sw      in  auto-run select (only with STEP_CTRL_AUTORUN_EN)
//   step_en     out one-cycle pulse per accepted step press (or auto-run tick)
//   peek        out debounced peek level, active-high
//   step_busy   out high from accepted step press until accepted release
// Optional feature macro: STEP_CTRL_AUTORUN_EN adds a free-running step
// divider enabled by run_sw; without it run_sw is ignored.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned RUN_DIV         = 25_000_000
) (
  input  logic clk50,
  input  logic reset,
  input  logic key_step_n,
  input  logic key_peek_n,
  input  logic run_sw,
  output logic step_en,
  output logic peek,
  output logic step_busy
);

  logic        step_lvl;
  logic        peek_lvl;
  logic        run_tick;
  logic        run_active;
  step_state_t state;
  step_state_t state_next;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk50 (clk50),
    .reset (reset),
    .key_n (key_step_n),
    .level (step_lvl)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek_db (
    .clk50 (clk50),
    .reset (reset),
    .key_n (key_peek_n),
    .level (peek_lvl)
  );

  // The accepted level is already a flop inside the debouncer; adding another
  // stage would delay peek by a cycle.
  assign peek = peek_lvl;

`ifdef STEP_CTRL_AUTORUN_EN
  localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic [SYNC_STAGES-1:0] run_q;
  logic [DW-1:0]          div_cnt;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      run_q <= '0;
    end else begin
      run_q <= {run_q[SYNC_STAGES-2:0], run_sw};
    end
  end

  assign run_active = run_q[SYNC_STAGES-1];

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!run_active || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign run_tick = run_active && (div_cnt == DIV_LAST);
`else
  logic run_sw_unused;
  assign run_sw_unused = run_sw;
  assign run_active    = 1'b0;
  assign run_tick      = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (step_lvl) state_next = FIRE;
      FIRE:    state_next = HELD;
      HELD:    if (!step_lvl) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Auto-run parks the manual FSM so key presses are ignored.
    if (run_active) state_next = IDLE;
  end

  // Outputs are decoded from state_next so they line up with the state flop.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step_en   <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      state     <= state_next;
      step_en   <= (state_next == FIRE) || run_tick;
      step_busy <= (state_next != IDLE);
    end
  end

endmodule
